// File: rtl/accel_pkg.sv
// Shared types and constants for the host-side accelerator loader.
package accel_pkg;
    localparam int NUM_CELLS = 100;
    localparam int NUM_SHIPS = 5;
    localparam logic [2:0] SHIP_TERM = 3'd7;

    // Field LSB positions inside the 32-bit accelerator word
    localparam int SP1_LSB = 25;
    localparam int V1_LSB  = 24;
    localparam int T1_LSB  = 21;
    localparam int SP2_LSB = 14;
    localparam int V2_LSB  = 13;
    localparam int T2_LSB  = 10;

    typedef enum logic [1:0] {EMPTY = 2'b00, OCC = 2'b01} cell_t;

    typedef struct packed {
        logic [6:0] pos;
        logic       vert;
    } ship_t;

    typedef enum logic [2:0] {
        S_IDLE, S_BOARD, S_GAP1, S_SHIPS, S_GAP2, S_START, S_WAIT
    } state_t;
endpackage

// File: rtl/accel_loader_if.sv
// Loader-to-accelerator bus: packed data word, load strobes and result-valid.
interface accel_loader_if;
    logic [31:0] data;
    logic        update_board;
    logic        update_ship;
    logic        start;
    logic        valid_out;

    modport master (output data, update_board, update_ship, start, input valid_out);
    modport slave  (input data, update_board, update_ship, start, output valid_out);
endinterface

// File: rtl/accel_word_pack.sv
// Packs two {space, vert, type} slots into the accelerator data word.
module accel_word_pack
    import accel_pkg::*;
(
    input  logic [6:0]  space1,
    input  logic        vert1,
    input  logic [2:0]  type1,
    input  logic [6:0]  space2,
    input  logic        vert2,
    input  logic [2:0]  type2,
    output logic [31:0] word
);
    always_comb begin
        word = '0;
        word[SP1_LSB +: 7] = space1;
        word[V1_LSB]       = vert1;
        word[T1_LSB +: 3]  = type1;
        word[SP2_LSB +: 7] = space2;
        word[V2_LSB]       = vert2;
        word[T2_LSB +: 3]  = type2;
    end
endmodule

// File: rtl/accel_loader.sv
// Holds the host board/ship image and streams it to the accelerator on go,
// then waits for the result with a bounded timeout.
module accel_loader
    import accel_pkg::*;
#(
    parameter int TIMEOUT = 4096,
    parameter int TW      = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cell_we,
    input  logic [6:0] cell_addr,
    input  logic [1:0] cell_val,
    input  logic       ship_we,
    input  logic [2:0] ship_idx,
    input  logic [6:0] ship_pos,
    input  logic       ship_vert,
    input  logic       go,
    accel_loader_if.master acc,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic       wr_drop
);
    state_t        state, state_n;
    logic [6:0]    idx, idx_n;
    logic [TW-1:0] to_cnt, to_n;
    logic          done_n, tmo_n;
    logic [1:0]    cells [NUM_CELLS];
    ship_t         ships [NUM_SHIPS];
    logic          idle, cell_ok, ship_ok;

    logic [6:0]  s1, s2;
    logic        v1, v2;
    logic [2:0]  t1, t2;
    logic [31:0] word;

    assign idle    = (state == S_IDLE);
    assign cell_ok = cell_we && idle && (cell_addr < 7'(NUM_CELLS));
    assign ship_ok = ship_we && idle && (ship_idx < 3'(NUM_SHIPS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CELLS; i++) cells[i] <= EMPTY;
            for (int i = 0; i < NUM_SHIPS; i++) ships[i] <= '0;
        end else begin
            if (cell_ok) cells[cell_addr] <= cell_val;
            if (ship_ok) ships[ship_idx] <= '{pos: ship_pos, vert: ship_vert};
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        to_n    = to_cnt;
        done_n  = 1'b0;
        tmo_n   = timeout;
        unique case (state)
            S_IDLE: if (go) begin
                state_n = S_BOARD;
                idx_n   = '0;
                tmo_n   = 1'b0;
            end
            S_BOARD: if (idx == 7'(NUM_CELLS - 1)) begin
                state_n = S_GAP1;
                idx_n   = '0;
            end else idx_n = idx + 7'd1;
            S_GAP1: state_n = S_SHIPS;
            S_SHIPS: if (idx == 7'd2) begin
                state_n = S_GAP2;
                idx_n   = '0;
            end else idx_n = idx + 7'd1;
            S_GAP2: state_n = S_START;
            S_START: begin
                state_n = S_WAIT;
                to_n    = '0;
            end
            S_WAIT: begin
                to_n = to_cnt + TW'(1);
                // A result arriving on the expiry cycle still counts as success
                if (acc.valid_out) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                    tmo_n   = 1'b0;
                end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                    tmo_n   = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Word contents are decoded from the next state so the bus is registered
    always_comb begin
        s1 = '0; v1 = 1'b0; t1 = '0;
        s2 = '0; v2 = 1'b0; t2 = '0;
        case (state_n)
            S_BOARD: begin
                s1 = idx_n;
                t1 = {1'b0, cells[idx_n]};
            end
            S_SHIPS: case (idx_n)
                7'd0: begin
                    s1 = ships[0].pos; v1 = ships[0].vert; t1 = 3'd0;
                    s2 = ships[1].pos; v2 = ships[1].vert; t2 = 3'd1;
                end
                7'd1: begin
                    s1 = ships[2].pos; v1 = ships[2].vert; t1 = 3'd2;
                    s2 = ships[3].pos; v2 = ships[3].vert; t2 = 3'd3;
                end
                default: begin
                    s1 = ships[4].pos; v1 = ships[4].vert; t1 = 3'd4;
                    s2 = ships[0].pos; v2 = ships[0].vert; t2 = SHIP_TERM;
                end
            endcase
            default: ;
        endcase
    end

    accel_word_pack u_pack (
        .space1(s1), .vert1(v1), .type1(t1),
        .space2(s2), .vert2(v2), .type2(t2),
        .word  (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            idx              <= '0;
            to_cnt           <= '0;
            acc.data         <= '0;
            acc.update_board <= 1'b0;
            acc.update_ship  <= 1'b0;
            acc.start        <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            timeout          <= 1'b0;
            wr_drop          <= 1'b0;
        end else begin
            state            <= state_n;
            idx              <= idx_n;
            to_cnt           <= to_n;
            acc.data         <= word;
            acc.update_board <= (state_n == S_BOARD);
            acc.update_ship  <= (state_n == S_SHIPS);
            acc.start        <= (state_n == S_START);
            busy             <= (state_n != S_IDLE);
            done             <= done_n;
            timeout          <= tmo_n;
            wr_drop          <= (cell_we && !cell_ok) || (ship_we && !ship_ok);
        end
    end
endmodule
